// File: rtl/multiplexor_io_reg.sv
// rtl/multiplexor_io_reg.sv - registered R-channel input capture with 1-cycle selected read
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   datain     R*T packed channel data, channel 0 in the LSBs
//   in_we      per-channel capture strobe
//   rd_en      read request
//   selection  channel index for the read
//   dataout    registered read data (holds between reads)
//   rd_valid   pulse: dataout updated by a read
//   fresh      bit k set when channel k captured since its last read
//   sel_err    pulse: read selected a channel index >= R
module multiplexor_io_reg #(
  parameter int R = 2,
  parameter int T = 8,
  parameter int N = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R*T-1:0] datain,
  input  logic [R-1:0]   in_we,
  input  logic           rd_en,
  input  logic [N-1:0]   selection,
  output logic [T-1:0]   dataout,
  output logic           rd_valid,
  output logic [R-1:0]   fresh,
  output logic           sel_err
);

  // R expressed one bit wider than selection so the range test is exact
  // even when 2^N == R.
  localparam logic [N:0] RMAX = (N+1)'(R);

  logic [T-1:0] hold_q [R];
  logic [T-1:0] hold_d [R];
  logic [R-1:0] fresh_q, fresh_d;
  logic [T-1:0] dataout_q, dataout_d;
  logic         rd_valid_q, rd_valid_d;
  logic         sel_err_q, sel_err_d;

  logic         sel_in_range;
  logic [T-1:0] sel_data;

  assign sel_in_range = ({1'b0, selection} < RMAX);

  // Selected channel with write-through: a same-cycle capture is what the
  // reader sees.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < R; k++) begin
      if (selection == N'(k)) begin
        sel_data = in_we[k] ? datain[k*T +: T] : hold_q[k];
      end
    end
  end

  always_comb begin
    hold_d     = hold_q;
    fresh_d    = fresh_q;
    dataout_d  = dataout_q;
    rd_valid_d = 1'b0;
    sel_err_d  = 1'b0;

    for (int k = 0; k < R; k++) begin
      if (in_we[k]) begin
        hold_d[k]  = datain[k*T +: T];
        fresh_d[k] = 1'b1;
      end
    end

    if (rd_en) begin
      rd_valid_d = 1'b1;
      if (sel_in_range) begin
        dataout_d = sel_data;
        // Applied after the capture loop so a read clears the bit even when
        // the same channel captures this cycle.
        for (int k = 0; k < R; k++) begin
          if (selection == N'(k)) begin
            fresh_d[k] = 1'b0;
          end
        end
      end else begin
        dataout_d = '0;
        sel_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < R; k++) begin
        hold_q[k] <= '0;
      end
      fresh_q    <= '0;
      dataout_q  <= '0;
      rd_valid_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      for (int k = 0; k < R; k++) begin
        hold_q[k] <= hold_d[k];
      end
      fresh_q    <= fresh_d;
      dataout_q  <= dataout_d;
      rd_valid_q <= rd_valid_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign dataout  = dataout_q;
  assign rd_valid = rd_valid_q;
  assign fresh    = fresh_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_multiplexor_io_reg.sv
// tb/tb_multiplexor_io_reg.sv - directed self-checking bench for multiplexor_io_reg
module tb_multiplexor_io_reg;

  logic clk;
  logic rst_n;

  // Instance A: R=2, T=8, N=1
  logic [15:0] datain_a;
  logic [1:0]  in_we_a;
  logic        rd_en_a;
  logic [0:0]  sel_a;
  logic [7:0]  dataout_a;
  logic        rd_valid_a;
  logic [1:0]  fresh_a;
  logic        sel_err_a;

  // Instance B: R=3, T=8, N=2
  logic [23:0] datain_b;
  logic [2:0]  in_we_b;
  logic        rd_en_b;
  logic [1:0]  sel_b;
  logic [7:0]  dataout_b;
  logic        rd_valid_b;
  logic [2:0]  fresh_b;
  logic        sel_err_b;

  int checks;
  int errors;

  multiplexor_io_reg #(.R(2), .T(8), .N(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .datain(datain_a), .in_we(in_we_a),
    .rd_en(rd_en_a), .selection(sel_a), .dataout(dataout_a),
    .rd_valid(rd_valid_a), .fresh(fresh_a), .sel_err(sel_err_a)
  );

  multiplexor_io_reg #(.R(3), .T(8), .N(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .datain(datain_b), .in_we(in_we_b),
    .rd_en(rd_en_b), .selection(sel_b), .dataout(dataout_b),
    .rd_valid(rd_valid_b), .fresh(fresh_b), .sel_err(sel_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are changed and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    datain_a = '0; in_we_a = '0; rd_en_a = 1'b0; sel_a = '0;
    datain_b = '0; in_we_b = '0; rd_en_b = 1'b0; sel_b = '0;
  endtask

  task automatic test_reset();
    datain_a = 16'hFFFF; in_we_a = 2'b11; rd_en_a = 1'b1; sel_a = 1'b1;
    tick();
    // Registers now nonzero: dataout=FF, rd_valid=1, fresh=01.
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dataout_a !== 8'h00) begin errors++; $display("FAIL reset_async_dataout got %h expected %h", dataout_a, 8'h00); end
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL reset_async_rd_valid got %b expected %b", rd_valid_a, 1'b0); end
    checks++; if (fresh_a !== 2'b00) begin errors++; $display("FAIL reset_async_fresh got %b expected %b", fresh_a, 2'b00); end
    checks++; if (sel_err_a !== 1'b0) begin errors++; $display("FAIL reset_async_sel_err got %b expected %b", sel_err_a, 1'b0); end
    idle_inputs();
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (dataout_a !== 8'h00) begin errors++; $display("FAIL reset_release_dataout got %h expected %h", dataout_a, 8'h00); end
    checks++; if (fresh_a !== 2'b00) begin errors++; $display("FAIL reset_release_fresh got %b expected %b", fresh_a, 2'b00); end
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL reset_release_rd_valid got %b expected %b", rd_valid_a, 1'b0); end
  endtask

  task automatic test_capture_read();
    in_we_a = 2'b01; datain_a = 16'hA55A; rd_en_a = 1'b0;
    tick();
    checks++; if (fresh_a !== 2'b01) begin errors++; $display("FAIL capture_fresh got %b expected %b", fresh_a, 2'b01); end
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL capture_rd_valid got %b expected %b", rd_valid_a, 1'b0); end
    in_we_a = 2'b00; datain_a = 16'h0000; rd_en_a = 1'b1; sel_a = 1'b0;
    tick();
    checks++; if (dataout_a !== 8'h5A) begin errors++; $display("FAIL read0_dataout got %h expected %h", dataout_a, 8'h5A); end
    checks++; if (rd_valid_a !== 1'b1) begin errors++; $display("FAIL read0_rd_valid got %b expected %b", rd_valid_a, 1'b1); end
    checks++; if (fresh_a !== 2'b00) begin errors++; $display("FAIL read0_fresh got %b expected %b", fresh_a, 2'b00); end
    rd_en_a = 1'b0;
    tick();
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL idle_rd_valid got %b expected %b", rd_valid_a, 1'b0); end
    checks++; if (dataout_a !== 8'h5A) begin errors++; $display("FAIL idle_dataout_hold got %h expected %h", dataout_a, 8'h5A); end
  endtask

  task automatic test_bypass();
    in_we_a = 2'b10; datain_a = 16'h3C00; rd_en_a = 1'b1; sel_a = 1'b1;
    tick();
    checks++; if (dataout_a !== 8'h3C) begin errors++; $display("FAIL bypass_dataout got %h expected %h", dataout_a, 8'h3C); end
    checks++; if (fresh_a !== 2'b00) begin errors++; $display("FAIL bypass_fresh got %b expected %b", fresh_a, 2'b00); end
    checks++; if (rd_valid_a !== 1'b1) begin errors++; $display("FAIL bypass_rd_valid got %b expected %b", rd_valid_a, 1'b1); end
    in_we_a = 2'b00; datain_a = 16'h0000; rd_en_a = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [3];
    logic [0:0] sel_seq [3];
    exp_seq[0] = 8'h5A; exp_seq[1] = 8'h3C; exp_seq[2] = 8'h5A;
    sel_seq[0] = 1'b0;  sel_seq[1] = 1'b1;  sel_seq[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en_a = 1'b1; sel_a = sel_seq[i];
      tick();
      checks++; if (dataout_a !== exp_seq[i]) begin errors++; $display("FAIL b2b_dataout[%0d] got %h expected %h", i, dataout_a, exp_seq[i]); end
      checks++; if (rd_valid_a !== 1'b1) begin errors++; $display("FAIL b2b_rd_valid[%0d] got %b expected %b", i, rd_valid_a, 1'b1); end
    end
    rd_en_a = 1'b0;
    tick();
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL b2b_end_rd_valid got %b expected %b", rd_valid_a, 1'b0); end
    checks++; if (dataout_a !== 8'h5A) begin errors++; $display("FAIL b2b_end_dataout got %h expected %h", dataout_a, 8'h5A); end
    checks++; if (fresh_a !== 2'b00) begin errors++; $display("FAIL b2b_reread_fresh got %b expected %b", fresh_a, 2'b00); end
  endtask

  task automatic test_mixed_capture_read();
    // Both channels capture; channel 1 is read and consumed, channel 0 stays fresh.
    in_we_a = 2'b11; datain_a = 16'h7766; rd_en_a = 1'b1; sel_a = 1'b1;
    tick();
    checks++; if (dataout_a !== 8'h77) begin errors++; $display("FAIL mixed_dataout got %h expected %h", dataout_a, 8'h77); end
    checks++; if (fresh_a !== 2'b01) begin errors++; $display("FAIL mixed_fresh got %b expected %b", fresh_a, 2'b01); end
    in_we_a = 2'b00; datain_a = 16'h0000; rd_en_a = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    in_we_b = 3'b111; datain_b = 24'h332211; rd_en_b = 1'b0;
    tick();
    checks++; if (fresh_b !== 3'b111) begin errors++; $display("FAIL oor_pre_fresh got %b expected %b", fresh_b, 3'b111); end
    // Out-of-range read with a concurrent capture on channel 1.
    in_we_b = 3'b010; datain_b = 24'h005500; rd_en_b = 1'b1; sel_b = 2'd3;
    tick();
    checks++; if (dataout_b !== 8'h00) begin errors++; $display("FAIL oor_dataout got %h expected %h", dataout_b, 8'h00); end
    checks++; if (rd_valid_b !== 1'b1) begin errors++; $display("FAIL oor_rd_valid got %b expected %b", rd_valid_b, 1'b1); end
    checks++; if (sel_err_b !== 1'b1) begin errors++; $display("FAIL oor_sel_err got %b expected %b", sel_err_b, 1'b1); end
    checks++; if (fresh_b !== 3'b111) begin errors++; $display("FAIL oor_fresh got %b expected %b", fresh_b, 3'b111); end
    in_we_b = 3'b000; datain_b = 24'h000000; rd_en_b = 1'b0;
    tick();
    checks++; if (sel_err_b !== 1'b0) begin errors++; $display("FAIL oor_sel_err_pulse got %b expected %b", sel_err_b, 1'b0); end
    checks++; if (rd_valid_b !== 1'b0) begin errors++; $display("FAIL oor_rd_valid_pulse got %b expected %b", rd_valid_b, 1'b0); end
    rd_en_b = 1'b1; sel_b = 2'd1;
    tick();
    checks++; if (dataout_b !== 8'h55) begin errors++; $display("FAIL b_read1_dataout got %h expected %h", dataout_b, 8'h55); end
    checks++; if (fresh_b !== 3'b101) begin errors++; $display("FAIL b_read1_fresh got %b expected %b", fresh_b, 3'b101); end
    checks++; if (sel_err_b !== 1'b0) begin errors++; $display("FAIL b_read1_sel_err got %b expected %b", sel_err_b, 1'b0); end
    sel_b = 2'd2;
    tick();
    checks++; if (dataout_b !== 8'h33) begin errors++; $display("FAIL b_read2_dataout got %h expected %h", dataout_b, 8'h33); end
    checks++; if (fresh_b !== 3'b001) begin errors++; $display("FAIL b_read2_fresh got %b expected %b", fresh_b, 3'b001); end
    rd_en_b = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    rd_en_a = 1'b1; sel_a = 1'b0; in_we_a = 2'b01; datain_a = 16'h00EE;
    rst_n = 1'b0;
    tick();
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid got %b expected %b", rd_valid_a, 1'b0); end
    checks++; if (dataout_a !== 8'h00) begin errors++; $display("FAIL midrst_dataout got %h expected %h", dataout_a, 8'h00); end
    checks++; if (fresh_a !== 2'b00) begin errors++; $display("FAIL midrst_fresh got %b expected %b", fresh_a, 2'b00); end
    idle_inputs();
    rst_n = 1'b1;
    tick();
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_release_rd_valid got %b expected %b", rd_valid_a, 1'b0); end
    // Holding register for channel 0 (previously 66) must read back cleared.
    rd_en_a = 1'b1; sel_a = 1'b0;
    tick();
    checks++; if (dataout_a !== 8'h00) begin errors++; $display("FAIL midrst_hold_cleared got %h expected %h", dataout_a, 8'h00); end
    checks++; if (rd_valid_a !== 1'b1) begin errors++; $display("FAIL midrst_reread_rd_valid got %b expected %b", rd_valid_a, 1'b1); end
    rd_en_a = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_capture_read();
    test_bypass();
    test_back_to_back();
    test_mixed_capture_read();
    test_out_of_range();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
